// File: rtl/serial_pkg.sv
// Shared serial-line definitions used by both the transmit and receive sides.
package serial_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// Producer-side valid/ready word handshake into the serial transmitter.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Free-running bit-period counter; bit_done marks the last cycle of each bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // With CLKS_PER_BIT = 1 bit_done is permanently high and the count stays at 0.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || bit_done) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W bits LSB first, stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus,
    output logic        tx_out,
    output logic        busy
);
    localparam int IW = $clog2(DATA_W) + 1;

    tx_state_t         state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [IW-1:0]     idx_q;
    logic              tx_q, busy_q, ready_q;
    logic              accept, bit_done;
    logic [DATA_W-1:0] shreg_nx;

    assign accept   = (state_q == IDLE) && bus.valid_in;
    assign shreg_nx = shreg_q >> 1;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (bus.valid_in) begin
                    shreg_q <= bus.data_in;
                    idx_q   <= '0;
                    state_q <= START;
                    tx_q    <= START_BIT;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
                START: if (bit_done) begin
                    state_q <= DATA;
                    idx_q   <= '0;
                    tx_q    <= shreg_q[0];
                end
                // tx_q is loaded with the bit that will be on the line next cycle.
                DATA: if (bit_done) begin
                    if (idx_q == IW'(DATA_W - 1)) begin
                        state_q <= STOP;
                        tx_q    <= STOP_BIT;
                    end else begin
                        shreg_q <= shreg_nx;
                        idx_q   <= idx_q + IW'(1);
                        tx_q    <= shreg_nx[0];
                    end
                end
                STOP: if (bit_done) begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_out        = tx_q;
    assign busy          = busy_q;
    assign bus.ready_out = ready_q;
endmodule
